// File: rtl/seg_frame_reader.sv
// Rebuilds a 4-digit BCD value from a time-multiplexed active-low 7-segment bus.
// Define SEG_READER_HEX_EN to also accept the A..F hex glyphs.
module seg_frame_reader #(
    parameter int STABLE_FRAMES = 3,
    parameter int NDIG          = 4
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [0:6]  seg_in,
    input  logic [1:0]  seg_idx,
    input  logic        seg_valid,
    output logic [15:0] bcd_out,
    output logic [3:0]  blank_mask,
    output logic        out_valid,
    output logic        seq_err,
    output logic        pat_err
);

    localparam logic [1:0] LAST_IDX = 2'(NDIG - 1);
    localparam logic [3:0] SF_CNT   = 4'(STABLE_FRAMES);

    logic [3:0]  dec_nib;
    logic        dec_blank;
    logic        dec_bad;

    logic [1:0]  exp_idx;
    logic [11:0] cur_nib;
    logic [2:0]  cur_blank;
    logic        cur_bad;

    logic [15:0] prev_nib;
    logic [3:0]  prev_blank;
    logic        prev_valid;
    logic [3:0]  stable_cnt;
    logic        published;

    logic [15:0] frame_nib;
    logic [3:0]  frame_blank;
    logic        frame_bad;
    logic        frame_match;

    // A blank glyph decodes to nibble 0 but is tracked separately via dec_blank.
    always_comb begin
        dec_nib   = 4'h0;
        dec_blank = 1'b0;
        dec_bad   = 1'b0;
        case (seg_in)
            7'b0000001: dec_nib = 4'h0;
            7'b1001111: dec_nib = 4'h1;
            7'b0010010: dec_nib = 4'h2;
            7'b0000110: dec_nib = 4'h3;
            7'b1001100: dec_nib = 4'h4;
            7'b0100100: dec_nib = 4'h5;
            7'b0100000: dec_nib = 4'h6;
            7'b0001111: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0000100: dec_nib = 4'h9;
`ifdef SEG_READER_HEX_EN
            7'b0001000: dec_nib = 4'hA;
            7'b1100000: dec_nib = 4'hB;
            7'b0110001: dec_nib = 4'hC;
            7'b1000010: dec_nib = 4'hD;
            7'b0110000: dec_nib = 4'hE;
            7'b0111000: dec_nib = 4'hF;
`endif
            7'b1111111: dec_blank = 1'b1;
            default:    dec_bad   = 1'b1;
        endcase
    end

    // The slot-3 sample is merged in combinationally so a frame is judged on the accepting edge.
    always_comb begin
        frame_nib   = {dec_nib, cur_nib};
        frame_blank = {dec_blank, cur_blank};
        frame_bad   = cur_bad | dec_bad;
        frame_match = prev_valid && (frame_nib == prev_nib) && (frame_blank == prev_blank);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bcd_out    <= 16'h0000;
            blank_mask <= 4'hF;
            out_valid  <= 1'b0;
            seq_err    <= 1'b0;
            pat_err    <= 1'b0;
            exp_idx    <= 2'd0;
            cur_nib    <= 12'h000;
            cur_blank  <= 3'b000;
            cur_bad    <= 1'b0;
            prev_nib   <= 16'h0000;
            prev_blank <= 4'h0;
            prev_valid <= 1'b0;
            stable_cnt <= 4'd0;
            published  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            seq_err   <= 1'b0;
            pat_err   <= 1'b0;
            if (seg_valid) begin
                if (seg_idx == exp_idx) begin
                    exp_idx <= exp_idx + 2'd1;
                    case (seg_idx)
                        2'd0: begin
                            cur_nib[3:0] <= dec_nib;
                            cur_blank[0] <= dec_blank;
                            cur_bad      <= dec_bad;
                        end
                        2'd1: begin
                            cur_nib[7:4] <= dec_nib;
                            cur_blank[1] <= dec_blank;
                            cur_bad      <= cur_bad | dec_bad;
                        end
                        2'd2: begin
                            cur_nib[11:8] <= dec_nib;
                            cur_blank[2]  <= dec_blank;
                            cur_bad       <= cur_bad | dec_bad;
                        end
                        default: ;
                    endcase
                    if (seg_idx == LAST_IDX) begin
                        if (frame_bad) begin
                            pat_err    <= 1'b1;
                            stable_cnt <= 4'd0;
                            prev_valid <= 1'b0;
                            prev_nib   <= 16'h0000;
                            prev_blank <= 4'h0;
                        end else if (frame_match) begin
                            if (stable_cnt < SF_CNT)
                                stable_cnt <= stable_cnt + 4'd1;
                            if ((stable_cnt >= SF_CNT - 4'd1) && !published) begin
                                bcd_out    <= frame_nib;
                                blank_mask <= frame_blank;
                                out_valid  <= 1'b1;
                                published  <= 1'b1;
                            end
                        end else begin
                            prev_nib   <= frame_nib;
                            prev_blank <= frame_blank;
                            prev_valid <= 1'b1;
                            stable_cnt <= 4'd1;
                            if (SF_CNT == 4'd1) begin
                                bcd_out    <= frame_nib;
                                blank_mask <= frame_blank;
                                out_valid  <= 1'b1;
                                published  <= 1'b1;
                            end else begin
                                published  <= 1'b0;
                            end
                        end
                    end
                end else if (seg_idx == 2'd0) begin
                    // Slot 0 out of turn is treated as the start of a fresh frame.
                    seq_err      <= 1'b1;
                    exp_idx      <= 2'd1;
                    cur_nib[3:0] <= dec_nib;
                    cur_blank[0] <= dec_blank;
                    cur_bad      <= dec_bad;
                end else begin
                    seq_err <= 1'b1;
                    exp_idx <= 2'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_frame_reader.sv
// Scoreboard bench for seg_frame_reader: a frame-level reference model predicts pulses,
// a monitor matches them; honours SEG_READER_HEX_EN like the design.
module tb_seg_frame_reader;

    localparam int STABLE_FRAMES = 3;
    localparam int BLANK = 16;
    localparam int BAD   = -1;
    localparam int K_PUB = 0;
    localparam int K_SEQ = 1;
    localparam int K_PAT = 2;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [0:6]  seg_in;
    logic [1:0]  seg_idx;
    logic        seg_valid;
    logic [15:0] bcd_out;
    logic [3:0]  blank_mask;
    logic        out_valid;
    logic        seq_err;
    logic        pat_err;

    seg_frame_reader #(.STABLE_FRAMES(STABLE_FRAMES), .NDIG(4)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .seg_in     (seg_in),
        .seg_idx    (seg_idx),
        .seg_valid  (seg_valid),
        .bcd_out    (bcd_out),
        .blank_mask (blank_mask),
        .out_valid  (out_valid),
        .seq_err    (seq_err),
        .pat_err    (pat_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int          kind;
        logic [15:0] bcd;
        logic [3:0]  mask;
        int          cyc;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  n_vec = 0;
    int  n_fail = 0;

    int          m_exp;
    int          m_frame[4];
    bit          m_bad;
    int          m_prev[4];
    bit          m_prev_valid;
    int          m_stable;
    bit          m_published;
    logic [15:0] m_pub_bcd;
    logic [3:0]  m_pub_mask;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    function automatic logic [6:0] patOf(input int c);
        case (c)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0000100;
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b0110001;
            13: return 7'b1000010;
            14: return 7'b0110000;
            15: return 7'b0111000;
            16: return 7'b1111111;
            default: return 7'b1111110;
        endcase
    endfunction

    function automatic int decodePat(input logic [6:0] p);
        for (int k = 0; k < 17; k++) begin
            if (patOf(k) == p) begin
                if (k < 10) return k;
                if (k == 16) return BLANK;
`ifdef SEG_READER_HEX_EN
                return k;
`else
                return BAD;
`endif
            end
        end
        return BAD;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, wanted %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushEv(input int kind);
        ev_t e;
        e.kind = kind;
        e.bcd  = m_pub_bcd;
        e.mask = m_pub_mask;
        e.cyc  = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic modelReset();
        m_exp        = 0;
        m_bad        = 0;
        m_prev_valid = 0;
        m_stable     = 0;
        m_published  = 0;
        m_pub_bcd    = 16'h0000;
        m_pub_mask   = 4'hF;
        for (int i = 0; i < 4; i++) begin
            m_frame[i] = 0;
            m_prev[i]  = 0;
        end
    endtask

    task automatic modelFrameDone();
        bit same;
        if (m_bad) begin
            pushEv(K_PAT);
            m_stable     = 0;
            m_prev_valid = 0;
            return;
        end
        same = m_prev_valid;
        for (int i = 0; i < 4; i++)
            if (m_frame[i] != m_prev[i]) same = 0;
        if (same) begin
            if (m_stable < STABLE_FRAMES) m_stable++;
        end else begin
            m_prev       = m_frame;
            m_prev_valid = 1;
            m_stable     = 1;
            m_published  = 0;
        end
        if (m_stable == STABLE_FRAMES && !m_published) begin
            m_published = 1;
            m_pub_bcd   = 16'h0000;
            m_pub_mask  = 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (m_frame[i] == BLANK) m_pub_mask[i] = 1'b1;
                else m_pub_bcd = m_pub_bcd | 16'(m_frame[i] << (4 * i));
            end
            pushEv(K_PUB);
        end
    endtask

    task automatic modelStep(input int idx, input logic [6:0] p);
        int code = decodePat(p);
        if (idx == m_exp) begin
            if (idx == 0) m_bad = 0;
            m_frame[idx] = code;
            if (code == BAD) m_bad = 1;
            if (idx == 3) modelFrameDone();
            m_exp = (m_exp + 1) % 4;
        end else if (idx == 0) begin
            pushEv(K_SEQ);
            m_frame[0] = code;
            m_bad      = (code == BAD);
            m_exp      = 1;
        end else begin
            pushEv(K_SEQ);
            m_exp = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic applyStimulus(input int idx, input int code);
        seg_in    = patOf(code);
        seg_idx   = 2'(idx);
        seg_valid = 1'b1;
        modelStep(idx, patOf(code));
        @(posedge CLOCK_50);
        #1;
        seg_valid = 1'b0;
    endtask

    task automatic sendFrame(input int c0, input int c1, input int c2, input int c3, input int reps);
        repeat (reps) begin
            applyStimulus(0, c0);
            applyStimulus(1, c1);
            applyStimulus(2, c2);
            applyStimulus(3, c3);
        end
    endtask

    task automatic checkHeld(input string tag);
        checkOutput({tag, "_bcd"}, 32'(bcd_out), 32'(m_pub_bcd));
        checkOutput({tag, "_mask"}, 32'(blank_mask), 32'(m_pub_mask));
    endtask

    task automatic doReset();
        reset     = 1'b1;
        seg_valid = 1'b0;
        idle(2);
        reset = 1'b0;
        modelReset();
        sb.delete();
        checkHeld("reset");
        checkOutput("reset_pulses", 32'({out_valid, seq_err, pat_err}), 32'h0);
    endtask

    // Pulses are matched in order; anything overdue in the queue is a missing pulse.
    ev_t mon_e;
    int  act_kind;
    always @(negedge CLOCK_50) begin
        if (!reset) begin
            if (out_valid || seq_err || pat_err) begin
                act_kind = out_valid ? K_PUB : (seq_err ? K_SEQ : K_PAT);
                if (sb.size() == 0) begin
                    checkOutput("spurious_pulse", 32'({out_valid, seq_err, pat_err}), 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("pulse_onehot", 32'($countones({out_valid, seq_err, pat_err})), 32'd1);
                    checkOutput("pulse_kind", 32'(act_kind), 32'(mon_e.kind));
                    checkOutput("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
                    if (mon_e.kind == K_PUB) begin
                        checkOutput("pub_bcd", 32'(bcd_out), 32'(mon_e.bcd));
                        checkOutput("pub_mask", 32'(blank_mask), 32'(mon_e.mask));
                    end
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                mon_e = sb.pop_front();
                checkOutput("missing_pulse", 32'({out_valid, seq_err, pat_err}), 32'(3'b100 >> mon_e.kind));
            end
        end
    end

    initial begin
        int cur[4];
        int r;
        bit wide;
        seg_in    = 7'b1111111;
        seg_idx   = 2'd0;
        seg_valid = 1'b0;
        doReset();

        sendFrame(1, 2, 3, 4, 3);
        checkHeld("first_pub");
        sendFrame(1, 2, 3, 4, 2);
        sendFrame(9, 0, 0, 5, 3);
        checkHeld("second_pub");
        sendFrame(7, 8, BLANK, 1, 3);
        checkHeld("blank_pub");

        applyStimulus(0, 2);
        applyStimulus(1, 2);
        applyStimulus(3, 2);
        applyStimulus(0, 6);
        applyStimulus(1, 6);
        applyStimulus(0, 6);
        applyStimulus(1, 6);
        applyStimulus(2, 6);
        applyStimulus(3, 6);
        sendFrame(6, 6, 6, 6, 2);
        checkHeld("seq_recover");

        sendFrame(3, 10, 3, 3, 1);
        sendFrame(0, 10, 0, 0, 3);
        checkHeld("hex_frame");
        sendFrame(17, 1, 1, 1, 1);

        sendFrame(5, 5, 1, 2, 2);
        idle(2);
        doReset();
        sendFrame(5, 5, 1, 2, 3);
        checkHeld("post_reset_pub");

        for (int i = 0; i < 4; i++) cur[i] = 0;
        for (int f = 0; f < 80; f++) begin
            if (f == 0 || $urandom_range(0, 3) == 0) begin
                wide = ($urandom_range(0, 4) == 0);
                for (int i = 0; i < 4; i++) begin
                    r = int'($urandom_range(0, 29));
                    if (!wide && r >= 10 && r < 16) r = r - 10;
                    if (!wide && r >= 28) r = 16;
                    cur[i] = (r < 16) ? r : (r < 26 ? r - 16 : (r < 28 ? BLANK : 17));
                end
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 24) == 0)
                    applyStimulus(int'($urandom_range(0, 3)), cur[i]);
                applyStimulus(i, cur[i]);
                idle(int'($urandom_range(0, 2)));
            end
        end
        checkHeld("random_end");

        idle(4);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
